// File: rtl/alu_pkg.sv
// alu_pkg: ALU mode constants and the default datapath width shared by the ALU blocks
package alu_pkg;
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;
    localparam int ALU_WIDTH = 32;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational SLICE-bit ripple of full-adder cells
module addsub_slice #(
    parameter int SLICE = 8
) (
    output logic             Carry,
    output logic             CarryMsbIn,
    output logic [SLICE-1:0] Sum,
    input  logic [SLICE-1:0] A,
    input  logic [SLICE-1:0] B,
    input  logic             Cin
);
    logic [SLICE:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign Sum[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign Carry      = c[SLICE];
    assign CarryMsbIn = c[SLICE-1];
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor resolving one SLICE per stage, with C/V/Z/N flags
// and a valid/ready handshake whose backpressure freezes the whole pipe.
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);
    localparam int SLICE = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [SLICE-1:0] sl  [STAGES];
    logic             v_d [STAGES];
    logic             c_d [STAGES];
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic             co  [STAGES];
    logic             cm  [STAGES];
    logic             ovf_q, zero_q, neg_q;

    assign adv      = !v_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    // B is inverted once at entry; the subtract +1 rides in as stage 0's carry-in
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_in
            assign a_d[k] = A;
            assign b_d[k] = (Sub == ALU_SUB) ? ~B : B;
            assign c_d[k] = Sub;
            assign s_d[k] = '0;
            assign v_d[k] = in_valid;
        end else begin : g_fwd
            assign a_d[k] = a_q[k-1];
            assign b_d[k] = b_q[k-1];
            assign c_d[k] = c_q[k-1];
            assign s_d[k] = s_q[k-1];
            assign v_d[k] = v_q[k-1];
        end
        addsub_slice #(.SLICE(SLICE)) u_slice (
            .Carry      (co[k]),
            .CarryMsbIn (cm[k]),
            .Sum        (sl[k]),
            .A          (a_d[k][k*SLICE +: SLICE]),
            .B          (b_d[k][k*SLICE +: SLICE]),
            .Cin        (c_d[k])
        );
        assign s_n[k] = s_d[k] | (WIDTH'(sl[k]) << (k * SLICE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= co[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_n[k];
            end
            ovf_q  <= cm[STAGES-1] ^ co[STAGES-1];
            zero_q <= s_n[STAGES-1] == '0;
            neg_q  <= s_n[STAGES-1][WIDTH-1];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign Sum       = s_q[STAGES-1];
    assign Carry     = c_q[STAGES-1];
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;
    assign Negative  = neg_q;
endmodule
